divisor_frecuencia: RTL and testbench
=====================================

Name: divisor_frecuencia

Overview:
- Parameterised integer clock divider. It derives a slow clock, clk_out, from the system clock clk, with 50% duty cycle for both even and odd ratios.
- It also produces a one-cycle tick strobe in the clk domain.
- It sits at the clocking front of the design and feeds frequency-selector and timing logic that needs a slow clock or a periodic enable.

Parameters:
- DIVISOR, 100000, division ratio N (integer, N >= 2); clk_out period = N clk periods (100 MHz -> 1 kHz by default)
- CNT_W, $clog2(DIVISOR), counter width (derived; must not be overridden)

Ports:
- clk  input  1  system clock, rising-edge active (falling edge used only for the odd-N duty correction)
- rst_n  input  1  asynchronous, active-low reset
- clk_out  output  1  divided clock, period N*Tclk, 50% duty
- tick  output  1  one-clk-cycle strobe, once per clk_out period

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset:
  - While rst_n=0: cnt=0, clk_out=0, tick=0, immediately and without waiting for an edge.
  - Reset is released synchronously to clk; first counting edge is the first rising clk edge with rst_n=1.
- Counter: on each rising edge, cnt <= (cnt == N-1) ? 0 : cnt+1; it wraps N-1 -> 0 with no idle cycle.
- Even N:
  - clk_out is the register q, updated as q <= (cnt_next >= N/2).
  - Low for N/2 clk cycles, then high for N/2 cycles.
  - First rising edge of clk_out comes N/2 rising clk edges after reset release.
- Odd N:
  - q <= (cnt_next >= (N+1)/2), which gives (N-1)/2 high cycles.
  - qn captures q on the falling clk edge; clk_out = q | qn.
  - High time is N/2 clk periods exactly (half-cycle extension); period is N.
  - qn is also cleared by rst_n.
- Glitch-free: clk_out comes only from registers, or from an OR of two registers whose transitions are half a cycle apart; there is no combinational counter decode on clk_out.
- tick:
  - Registered; high for exactly one clk cycle while cnt == N-1, i.e. the cycle before clk_out's falling edge (period boundary).
  - First tick is N cycles after reset release.
- Reset mid-operation: all outputs drop to 0 immediately. After release the sequence restarts from cnt=0 exactly as after power-up; there is no partial period.
- Parameter checks: DIVISOR < 2 is an elaboration-time error ($error / generate guard).
- No enable or runtime ratio change; the ratio is fixed at elaboration.

Decomposition:
- Shared package clk_div_pkg:
  - default DIVISOR constant and the system clock frequency constant (100 MHz)
  - helper function computing the counter width
- Single module; no sub-module is needed. The odd-N falling-edge stage is a generate branch inside divisor_frecuencia.

Test Plan:
- N=100000, clk 10 ns, rst_n low 100 ns then high, run 40 ms:
  - clk_out period = 1.000 ms and high time = 500 us, measured over 40 periods.
  - First clk_out rise at 500 us after release.
  - 40 tick pulses, each 10 ns wide.
- N=4: clk_out pattern after release is 0,0,1,1 repeating per clk cycle.
  - tick high on every 4th cycle (cnt=3), aligned with the cycle before clk_out falls.
- N=5:
  - clk_out period = 50 ns.
  - High time = 25 ns exactly, with one edge on a falling clk edge.
  - No glitch pulses narrower than 5 ns.
- N=2: clk_out toggles every rising edge (period 20 ns); tick high every other cycle.
- Reset mid-operation (N=4): assert rst_n at an arbitrary time, including between clk edges.
  - clk_out and tick go 0 immediately.
  - After release, the first clk_out rise comes exactly 2 rising edges later.
- Elaboration with DIVISOR=1 fails with an error message.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider.
package clk_div_pkg;

  // System clock and default slow-clock target (100 MHz -> 1 kHz).
  localparam int unsigned SysClkHz       = 100_000_000;
  localparam int unsigned OutClkHz       = 1_000;
  localparam int unsigned DefaultDivisor = SysClkHz / OutClkHz;

  // Counter width for a given ratio; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned divisor);
    return (divisor < 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/divisor_frecuencia.sv
// Integer clock divider: 50% duty slow clock for even and odd ratios, plus a
// one-cycle tick in the clk domain at every slow-clock period boundary.
module divisor_frecuencia
  import clk_div_pkg::*;
#(
  parameter int unsigned DIVISOR = DefaultDivisor
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out,
  output logic tick
);

  // Derived from DIVISOR; kept local so it cannot be overridden.
  localparam int unsigned      CNT_W   = cnt_width(DIVISOR);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(DIVISOR - 1);
  // (N+1)/2 equals N/2 for even N, so one threshold serves both cases.
  localparam logic [CNT_W-1:0] HighThr = CNT_W'((DIVISOR + 1) / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             tick_q, tick_d;

  // Next-state: wrapping counter, registered high-phase decode and tick.
  always_comb begin
    cnt_d  = (cnt_q == MaxCnt) ? '0 : cnt_q + 1'b1;
    q_d    = (cnt_d >= HighThr);
    tick_d = (cnt_d == MaxCnt);
  end

  // Rising-edge state; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      q_q    <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("divisor_frecuencia: DIVISOR must be >= 2");
  end

  if (DIVISOR % 2 == 0) begin : g_even
    assign clk_out = q_q;
  end else begin : g_odd
    logic qn_q, qn_d;

    // Half-cycle delayed copy of q stretches the high phase by half a clk.
    always_comb begin
      qn_d = q_q;
    end

    // Falling-edge stage for odd-ratio duty correction.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qn_q <= 1'b0;
      end else begin
        qn_q <= qn_d;
      end
    end

    // Both inputs are registers whose edges are half a cycle apart.
    assign clk_out = q_q | qn_q;
  end

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Self-checking bench: several divider instances share clk/rst_n.
module tb_divisor_frecuencia;

  localparam int NumDut = 5;
  localparam int NS [NumDut] = '{4, 5, 2, 7, 10};

  logic clk;
  logic rst_n;
  wire logic [NumDut-1:0] co;
  wire logic [NumDut-1:0] tk;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    divisor_frecuencia #(.DIVISOR(NS[g])) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_out(co[g]),
      .tick   (tk[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: q after j counting edges since release.
  function automatic bit qf(input int n, input int j);
    if (j <= 0) return 1'b0;
    return (j % n) >= (n + 1) / 2;
  endfunction

  typedef struct {
    int           m;
    bit           hi;
    logic [NumDut-1:0] co;
    logic [NumDut-1:0] tk;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int m, input bit hi);
    exp_t e;
    e.m  = m;
    e.hi = hi;
    for (int i = 0; i < NumDut; i++) begin
      if (hi && (NS[i] % 2 == 1)) e.co[i] = qf(NS[i], m) | qf(NS[i], m - 1);
      else                        e.co[i] = qf(NS[i], m);
      e.tk[i] = (m > 0) && ((m % NS[i]) == NS[i] - 1);
    end
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < NumDut; i++) begin
      chk($sformatf("clk_out N=%0d m=%0d hi=%0d", NS[i], e.m, e.hi), int'(co[i]), int'(e.co[i]));
      chk($sformatf("tick N=%0d m=%0d hi=%0d", NS[i], e.m, e.hi), int'(tk[i]), int'(e.tk[i]));
    end
  endtask

  // Pulse-width monitor on the N=5 output.
  bit  mon_en = 1'b0;
  bit  have_last = 1'b0;
  time last_edge = 0;
  time min_w = 1000000;
  always @(co[1]) begin
    if (mon_en) begin
      if (have_last && ($time - last_edge) < min_w) min_w = $time - last_edge;
      last_edge = $time;
      have_last = 1'b1;
    end
  end

  // Poll N=5 output every time unit until it reaches val (bounded).
  task automatic wait_lvl(input logic val, output time t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 300; i++) begin
      if (co[1] === val) begin
        t  = $time;
        ok = 1'b1;
        return;
      end
      #1;
    end
  endtask

  typedef struct {
    bit   rst;
    logic co4, tk4, co2, tk2;
  } vec_t;

  vec_t vt [12];

  initial begin
    int  m;
    int  edges;
    bit  ok;
    time r1, f1, r2;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held through several edges: all outputs stay low.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_clk_out", int'(co), 0);
    chk("reset_tick", int'(tk), 0);

    // Table phase: reset applied mid-low-phase, sampled just after rise.
    m = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      rst_n = vt[i].rst;
      @(posedge clk);
      #1;
      m = vt[i].rst ? m + 1 : 0;
      chk($sformatf("vec%0d clk_out N=4", i), int'(co[0]), int'(vt[i].co4));
      chk($sformatf("vec%0d tick N=4", i), int'(tk[0]), int'(vt[i].tk4));
      chk($sformatf("vec%0d clk_out N=2", i), int'(co[2]), int'(vt[i].co2));
      chk($sformatf("vec%0d tick N=2", i), int'(tk[2]), int'(vt[i].tk2));
    end

    // Free run: expectations queued at each rising edge, checked in both phases.
    mon_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      m++;
      sb.push_back(model(m, 1'b1));
      sb.push_back(model(m, 1'b0));
      #1;
      pop_check();
      @(negedge clk);
      #1;
      pop_check();
    end
    mon_en = 1'b0;

    // Asynchronous reset while N=4 clk_out is high, between clk edges.
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #3;
      if (co[0]) break;
    end
    chk("pre_reset_clk_out N=4", int'(co[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_clk_out", int'(co), 0);
    chk("async_reset_tick", int'(tk), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (edges = 1; edges <= 8; edges++) begin
      @(posedge clk);
      #1;
      if (co[0]) break;
    end
    chk("first_rise_after_reset N=4", edges, 2);

    // N=5 period, high time and pulse widths.
    have_last = 1'b0;
    min_w     = 1000000;
    mon_en    = 1'b1;
    @(negedge clk);
    #1;
    wait_lvl(1'b0, r1, ok);
    if (ok) wait_lvl(1'b1, r1, ok);
    if (ok) wait_lvl(1'b0, f1, ok);
    if (ok) wait_lvl(1'b1, r2, ok);
    chk("n5_edges_seen", int'(ok), 1);
    if (ok) begin
      chk("n5_period", int'(r2 - r1), 50);
      chk("n5_high_time", int'(f1 - r1), 25);
    end
    repeat (20) @(posedge clk);
    mon_en = 1'b0;
    chk("n5_min_pulse_ge5", int'(min_w >= 5), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
